// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter / normaliser with valid/ready flow control.
// Result, count and flags travel through LATENCY stages that advance together.
module shifter_pipe #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2,
    localparam int SW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW:0]      in_param,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_cnt,
    output logic             out_ovf,
    output logic             out_zero
);

    logic               right;
    logic [SW-1:0]      n;
    logic [SW-1:0]      k;
    logic               run;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-2:0]   ovf_mask;
    logic [WIDTH-2:0]   diff;
    logic [WIDTH-1:0]   res;
    logic [SW-1:0]      cnt;
    logic               ovf;
    logic               adv;

    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] o_q;
    logic [LATENCY-1:0] z_q;
    logic [WIDTH-1:0]   d_q [LATENCY];
    logic [SW-1:0]      c_q [LATENCY];

    // Decode the shift amount; MSB set means right by the low bits, else left by their negation
    always_comb begin
        right = in_param[SW];
        n     = in_param[SW-1:0];
        if (!right) begin
            n = -in_param[SW-1:0];
        end
    end

    // Normalisation count: number of bits below the sign that repeat the sign
    always_comb begin
        k   = '0;
        run = 1'b1;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (in_data[i] != in_data[WIDTH-1]) begin
                run = 1'b0;
            end
            if (run) begin
                k = k + SW'(1);
            end
        end
        if (in_data == '0) begin
            k = '0;
        end
    end

    // Shift datapath and overflow detection for the selected operation
    always_comb begin
        dbl_l    = {in_data, in_data} << n;
        dbl_r    = {in_data, in_data} >> n;
        ovf_mask = ~({(WIDTH-1){1'b1}} >> n);
        diff     = in_data[WIDTH-2:0] ^ {(WIDTH-1){in_data[WIDTH-1]}};
        res      = in_data;
        cnt      = n;
        ovf      = 1'b0;
        unique case (in_op)
            2'd0: begin
                if (right) res = dbl_r[WIDTH-1:0];
                else       res = dbl_l[2*WIDTH-1:WIDTH];
            end
            2'd1: begin
                if (right) res = in_data >> n;
                else       res = in_data << n;
            end
            2'd2: begin
                if (right) begin
                    res = $signed(in_data) >>> n;
                end else begin
                    res = {in_data[WIDTH-1], in_data[WIDTH-2:0] << n};
                    ovf = |(diff & ovf_mask);
                end
            end
            2'd3: begin
                res = in_data << k;
                cnt = k;
            end
        endcase
    end

    assign adv      = out_ready | ~v_q[LATENCY-1];
    assign in_ready = adv;

    // Pipeline stages: all advance together, all hold when the output is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            o_q <= '0;
            z_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            d_q[0] <= res;
            c_q[0] <= cnt;
            o_q[0] <= ovf;
            z_q[0] <= (res == '0);
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
                c_q[i] <= c_q[i-1];
                o_q[i] <= o_q[i-1];
                z_q[i] <= z_q[i-1];
            end
        end
    end

    assign out_valid = v_q[LATENCY-1];
    assign out_data  = d_q[LATENCY-1];
    assign out_cnt   = c_q[LATENCY-1];
    assign out_ovf   = o_q[LATENCY-1];
    assign out_zero  = z_q[LATENCY-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: three instances (LATENCY 1, 2, 4) share
// stimulus, one selected at a time; the others sit idle with out_ready high.
module tb_shifter_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [6:0]  in_param;
    logic [1:0]  in_op;
    logic [1:0]  sel;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [5:0]  out_cnt;
    logic        out_ovf;
    logic        out_zero;

    logic [2:0]  iv_i, or_i, ir_i, ov_i, of_i, oz_i;
    logic [63:0] od_i [3];
    logic [5:0]  oc_i [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iv_i[0] = in_valid && (sel == 2'd0);
    assign iv_i[1] = in_valid && (sel == 2'd1);
    assign iv_i[2] = in_valid && (sel == 2'd2);
    assign or_i[0] = (sel == 2'd0) ? out_ready : 1'b1;
    assign or_i[1] = (sel == 2'd1) ? out_ready : 1'b1;
    assign or_i[2] = (sel == 2'd2) ? out_ready : 1'b1;

    always_comb begin
        in_ready  = ir_i[sel];
        out_valid = ov_i[sel];
        out_data  = od_i[sel];
        out_cnt   = oc_i[sel];
        out_ovf   = of_i[sel];
        out_zero  = oz_i[sel];
    end

    shifter_pipe #(.WIDTH(64), .LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv_i[0]), .in_ready(ir_i[0]),
        .in_data(in_data), .in_param(in_param), .in_op(in_op),
        .out_valid(ov_i[0]), .out_ready(or_i[0]),
        .out_data(od_i[0]), .out_cnt(oc_i[0]),
        .out_ovf(of_i[0]), .out_zero(oz_i[0])
    );

    shifter_pipe #(.WIDTH(64), .LATENCY(2)) u_l2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv_i[1]), .in_ready(ir_i[1]),
        .in_data(in_data), .in_param(in_param), .in_op(in_op),
        .out_valid(ov_i[1]), .out_ready(or_i[1]),
        .out_data(od_i[1]), .out_cnt(oc_i[1]),
        .out_ovf(of_i[1]), .out_zero(oz_i[1])
    );

    shifter_pipe #(.WIDTH(64), .LATENCY(4)) u_l4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv_i[2]), .in_ready(ir_i[2]),
        .in_data(in_data), .in_param(in_param), .in_op(in_op),
        .out_valid(ov_i[2]), .out_ready(or_i[2]),
        .out_data(od_i[2]), .out_cnt(oc_i[2]),
        .out_ovf(of_i[2]), .out_zero(oz_i[2])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    // One word through the selected instance, output checked after its latency
    task automatic run1(input string tag, input logic [1:0] op,
                        input logic [6:0] p, input logic [63:0] d,
                        input logic [63:0] ed, input logic [5:0] ec,
                        input logic eo, input logic ez);
        int lat;
        lat = lat_of(sel);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_param  = p;
        in_data   = d;
        #1;
        check({tag, ".rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < lat; i++) begin
            #1;
            check({tag, ".early"}, 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        #1;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"}, out_data, ed);
        check({tag, ".cnt"}, 64'(out_cnt), 64'(ec));
        check({tag, ".ovf"}, 64'(out_ovf), 64'(eo));
        check({tag, ".zero"}, 64'(out_zero), 64'(ez));
    endtask

    // Five words, output stalled for the first six cycles, then drained
    task automatic stream(input logic [1:0] s);
        logic [63:0] w [5];
        logic [63:0] e [5];
        logic [63:0] got [$];
        logic [63:0] t;
        logic        take;
        int          acc;
        int          cyc;
        int          lat;
        sel = s;
        lat = lat_of(s);
        acc = 0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            t    = 64'h1111111111111111 * 64'(i + 1) + 64'h0F;
            w[i] = t;
            e[i] = {t[3:0], t[63:4]};
        end
        while (got.size() < 5 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (acc < 5);
            in_op     = 2'd0;
            in_param  = 7'h44;
            in_data   = (acc < 5) ? w[acc] : 64'd0;
            #1;
            if (cyc == 5) begin
                check("bp.ready_hold", 64'(in_ready), 64'd0);
                check("bp.acc_hold", 64'(acc), 64'(lat));
                check("bp.valid_hold", 64'(out_valid), 64'd1);
                check("bp.data_hold", out_data, e[0]);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            take = in_valid && in_ready;
            @(posedge clk);
            if (take) acc++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check("bp.order", got[i], e[i]);
        end
        repeat (3) @(negedge clk);
        #1;
        check("bp.drain", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_param  = '0;
        in_op     = '0;
        sel       = 2'd1;
        #1;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", out_data, 64'd0);
        check("rst.cnt", 64'(out_cnt), 64'd0);
        check("rst.zero", 64'(out_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run1("rotr4", 2'd0, 7'h44, 64'h0123456789ABCDEF,
             64'hF0123456789ABCDE, 6'd4, 1'b0, 1'b0);
        run1("arl1_ovf", 2'd2, 7'h3F, 64'h4000000000000000,
             64'h0, 6'd1, 1'b1, 1'b1);
        run1("norm_ff", 2'd3, 7'h00, 64'h00000000000000FF,
             64'h7F80000000000000, 6'd55, 1'b0, 1'b0);
        run1("norm_0", 2'd3, 7'h15, 64'h0,
             64'h0, 6'd0, 1'b0, 1'b1);
        run1("norm_ones", 2'd3, 7'h00, 64'hFFFFFFFFFFFFFFFF,
             64'h8000000000000000, 6'd63, 1'b0, 1'b0);
        run1("asr63", 2'd2, 7'h7F, 64'h8000000000000000,
             64'hFFFFFFFFFFFFFFFF, 6'd63, 1'b0, 1'b0);
        run1("lsr63", 2'd1, 7'h7F, 64'h8000000000000000,
             64'h1, 6'd63, 1'b0, 1'b0);
        run1("lsl4", 2'd1, 7'h3C, 64'h0123456789ABCDEF,
             64'h123456789ABCDEF0, 6'd4, 1'b0, 1'b0);
        run1("rotl8", 2'd0, 7'h38, 64'h0123456789ABCDEF,
             64'h23456789ABCDEF01, 6'd8, 1'b0, 1'b0);
        run1("ident", 2'd1, 7'h00, 64'hDEADBEEFCAFEF00D,
             64'hDEADBEEFCAFEF00D, 6'd0, 1'b0, 1'b0);
        run1("rotr0", 2'd0, 7'h40, 64'hDEADBEEFCAFEF00D,
             64'hDEADBEEFCAFEF00D, 6'd0, 1'b0, 1'b0);
        run1("asl4_ok", 2'd2, 7'h3C, 64'hF800000000000001,
             64'h8000000000000010, 6'd4, 1'b0, 1'b0);
        run1("asl4_neg_ovf", 2'd2, 7'h3C, 64'hC000000000000000,
             64'h8000000000000000, 6'd4, 1'b1, 1'b0);

        sel = 2'd0;
        run1("l1_rotr4", 2'd0, 7'h44, 64'h0123456789ABCDEF,
             64'hF0123456789ABCDE, 6'd4, 1'b0, 1'b0);
        sel = 2'd2;
        run1("l4_lsr63", 2'd1, 7'h7F, 64'h8000000000000000,
             64'h1, 6'd63, 1'b0, 1'b0);

        stream(2'd1);
        stream(2'd0);
        stream(2'd2);

        sel = 2'd1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'd1;
        in_param  = 7'h00;
        in_data   = 64'h55;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid.valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid.rst_valid", 64'(out_valid), 64'd0);
        check("mid.rst_data", out_data, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid.no_stale", 64'(out_valid), 64'd0);
        run1("post_rst", 2'd0, 7'h44, 64'h0123456789ABCDEF,
             64'hF0123456789ABCDE, 6'd4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
